// File: rtl/inqueue_mc.sv
// Multi-channel input queue: per-channel FWFT FIFOs drained by a round-robin reader; pushes appear one cycle later.
// Full channels either deassert ready (backpressure) or drop the tuple and count it (DROP_ON_FULL=1).

// Single-channel FWFT FIFO with occupancy counter and nearly-full flag.
module iq_fifo #(
  parameter int W      = 120,
  parameter int AW     = 4,
  parameter int NF_TH  = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdat_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         nearly_full_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o       = (cnt_q == '0);
  assign full_o        = (cnt_q == DEPTH_C);
  assign nearly_full_o = (32'(cnt_q) >= 32'(NF_TH));
  assign rdat_o        = mem[rd_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= wdat_i;
  end
endmodule

module inqueue_mc #(
  parameter int N_CH               = 4,
  parameter int ACTION_TUPLE_WIDTH = 128,
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int PKT_LEN_WIDTH      = 16,
  parameter int DEPTH_LOG2         = 4,
  parameter int NEARLY_FULL_TH     = 12,
  parameter int DROP_ON_FULL       = 0,
  localparam int CH_W              = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N_CH*ACTION_TUPLE_WIDTH-1:0]      tuple_in_data,
  input  logic [N_CH*PKT_LEN_WIDTH-1:0]           pkt_len_in,
  input  logic [N_CH-1:0]                         tuple_in_vld,
  output logic [N_CH-1:0]                         tuple_in_ready,
  output logic [PKT_LEN_WIDTH+PKT_TUPLE_WIDTH-1:0] fifo_data_out,
  output logic [CH_W-1:0]                         fifo_ch_out,
  input  logic                                    fifo_rd_en,
  output logic                                    fifo_empty,
  output logic [N_CH-1:0]                         fifo_nearly_full,
  output logic [31:0]                             drop_cnt
);
  localparam int ENT_W = PKT_LEN_WIDTH + PKT_TUPLE_WIDTH;
  localparam logic [CH_W:0]   NCH_W  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] NCH_M1 = CH_W'(N_CH - 1);

  logic [N_CH-1:0]  full, empty, push, pop, drops;
  logic [ENT_W-1:0] head [N_CH];
  logic [CH_W-1:0]  rr_q, rr_d, sel, idx;
  logic [CH_W:0]    idx_w;
  logic             found, pop_any;
  logic [5:0]       ndrop;
  logic [32:0]      drop_sum;
  logic [31:0]      drop_cnt_q, drop_cnt_d;
  logic             unused_tuple_bits;

  // Upper tuple bits beyond PKT_TUPLE_WIDTH are intentionally discarded.
  assign unused_tuple_bits = ^tuple_in_data;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign push[i] = tuple_in_vld[i] & ~full[i];
    assign pop[i]  = pop_any & (sel == CH_W'(i));

    iq_fifo #(
      .W     (ENT_W),
      .AW    (DEPTH_LOG2),
      .NF_TH (NEARLY_FULL_TH)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (push[i]),
      .pop_i         (pop[i]),
      .wdat_i        ({pkt_len_in[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH],
                       tuple_in_data[i*ACTION_TUPLE_WIDTH +: PKT_TUPLE_WIDTH]}),
      .rdat_o        (head[i]),
      .empty_o       (empty[i]),
      .full_o        (full[i]),
      .nearly_full_o (fifo_nearly_full[i])
    );
  end

  assign tuple_in_ready = (DROP_ON_FULL != 0) ? '1 : ~full;
  assign drops          = (DROP_ON_FULL != 0) ? (tuple_in_vld & full) : '0;

  assign fifo_empty = &empty;
  assign pop_any    = fifo_rd_en & ~fifo_empty;

  // Scan upward from rr_q with wrap; sel stays 0 when nothing is queued.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    idx_w = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx_w = {1'b0, rr_q} + (CH_W+1)'(k);
      if (idx_w >= NCH_W) idx_w = idx_w - NCH_W;
      idx = idx_w[CH_W-1:0];
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign fifo_ch_out   = sel;
  assign fifo_data_out = head[sel];

  always_comb begin
    rr_d = rr_q;
    if (pop_any) rr_d = (sel == NCH_M1) ? '0 : sel + 1'b1;
  end

  always_comb begin
    ndrop = '0;
    for (int k = 0; k < N_CH; k++) ndrop = ndrop + 6'(drops[k]);
    drop_sum   = {1'b0, drop_cnt_q} + {27'b0, ndrop};
    drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_q       <= rr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_inqueue_mc.sv
// Directed bench for inqueue_mc: a backpressure instance and a drop-mode instance share all inputs.
module tb_inqueue_mc;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] tin = '0;
  logic [63:0]  lin = '0;
  logic [3:0]   vld = '0;
  logic         rd_en = 1'b0;

  logic [3:0]   rdy_a, nf_a, rdy_b, nf_b;
  logic [119:0] dat_a, dat_b;
  logic [1:0]   ch_a, ch_b;
  logic         empty_a, empty_b;
  logic [31:0]  drop_a, drop_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inqueue_mc dut (
    .clk(clk), .reset(reset), .tuple_in_data(tin), .pkt_len_in(lin),
    .tuple_in_vld(vld), .tuple_in_ready(rdy_a), .fifo_data_out(dat_a),
    .fifo_ch_out(ch_a), .fifo_rd_en(rd_en), .fifo_empty(empty_a),
    .fifo_nearly_full(nf_a), .drop_cnt(drop_a)
  );

  inqueue_mc #(.DROP_ON_FULL(1)) dutd (
    .clk(clk), .reset(reset), .tuple_in_data(tin), .pkt_len_in(lin),
    .tuple_in_vld(vld), .tuple_in_ready(rdy_b), .fifo_data_out(dat_b),
    .fifo_ch_out(ch_b), .fifo_rd_en(rd_en), .fifo_empty(empty_b),
    .fifo_nearly_full(nf_b), .drop_cnt(drop_b)
  );

  task automatic set_ch(input int ch, input logic [127:0] t, input logic [15:0] l);
    tin[ch*128 +: 128] = t;
    lin[ch*16 +: 16]   = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vld   = '0;
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld   = 4'hF;
    rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    checks++; if (nf_a !== 4'h0) begin errors++; $display("FAIL reset_nf: got %h want 0", nf_a); end
    checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", ch_a); end
    checks++; if (rdy_a !== 4'hF) begin errors++; $display("FAIL reset_rdy: got %h want f", rdy_a); end
    checks++; if (drop_b !== 32'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_b); end
    checks++; if (empty_b !== 1'b1) begin errors++; $display("FAIL reset_empty_d: got %b want 1", empty_b); end
    vld   = '0;
    rd_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_ch(2, {24'hFFFFFF, 104'hA}, 16'h55);
    vld = 4'b0100;
    @(negedge clk);
    vld = '0;
    checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", empty_a); end
    checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d want 2", ch_a); end
    checks++; if (dat_a !== {16'h55, 104'hA}) begin errors++; $display("FAIL single_dat: got %h want %h", dat_a, {16'h55, 104'hA}); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b want 1", empty_a); end
    // A read while empty must not move the round-robin pointer (still 3 after popping ch2).
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    set_ch(1, 128'h11, 16'h1);
    set_ch(3, 128'h33, 16'h3);
    vld = 4'b1010;
    @(negedge clk);
    vld = '0;
    checks++; if (ch_a !== 2'd3) begin errors++; $display("FAIL rr_after_idle_ch: got %0d want 3", ch_a); end
    checks++; if (dat_a !== {16'h3, 104'h33}) begin errors++; $display("FAIL rr_after_idle_dat: got %h want %h", dat_a, {16'h3, 104'h33}); end
    rd_en = 1'b1;
    @(negedge clk);
    checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL rr_wrap_ch: got %0d want 1", ch_a); end
    checks++; if (dat_a !== {16'h1, 104'h11}) begin errors++; $display("FAIL rr_wrap_dat: got %h want %h", dat_a, {16'h1, 104'h11}); end
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rr_wrap_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 128'(16 + i), 16'(i));
    vld = 4'hF;
    @(negedge clk);
    vld = '0;
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ch_a !== 2'(k)) begin errors++; $display("FAIL rr_ch%0d: got %0d want %0d", k, ch_a, k); end
      checks++; if (dat_a !== {16'(k), 104'(16 + k)}) begin errors++; $display("FAIL rr_dat%0d: got %h want %h", k, dat_a, {16'(k), 104'(16 + k)}); end
      @(negedge clk);
    end
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rr_drained: got %b want 1", empty_a); end
    set_ch(0, 128'h20, 16'h0);
    set_ch(3, 128'h23, 16'h3);
    vld = 4'b1001;
    @(negedge clk);
    vld = '0;
    checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL rr_ptr_home: got %0d want 0", ch_a); end
  endtask

  task automatic test_backpressure();
    do_reset();
    vld = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      set_ch(1, {24'hABCDEF, 104'(k)}, 16'(100 + k));
      @(negedge clk);
      if (k == 10) begin checks++; if (nf_a[1] !== 1'b0) begin errors++; $display("FAIL nf_at_11: got %b want 0", nf_a[1]); end end
      if (k == 11) begin checks++; if (nf_a[1] !== 1'b1) begin errors++; $display("FAIL nf_at_12: got %b want 1", nf_a[1]); end end
      if (k == 14) begin checks++; if (rdy_a[1] !== 1'b1) begin errors++; $display("FAIL rdy_at_15: got %b want 1", rdy_a[1]); end end
    end
    checks++; if (rdy_a !== 4'b1101) begin errors++; $display("FAIL rdy_full: got %b want 1101", rdy_a); end
    set_ch(1, 128'h99, 16'h99);
    @(negedge clk);
    vld = '0;
    checks++; if (drop_a !== 32'd0) begin errors++; $display("FAIL bp_drop_cnt: got %0d want 0", drop_a); end
    checks++; if (drop_b !== 32'd1) begin errors++; $display("FAIL dm_drop_cnt: got %0d want 1", drop_b); end
    checks++; if (rdy_b !== 4'hF) begin errors++; $display("FAIL dm_rdy: got %h want f", rdy_b); end
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (dat_a !== {16'(100 + k), 104'(k)} || ch_a !== 2'd1) begin errors++; $display("FAIL bp_drain%0d: got ch %0d %h want ch 1 %h", k, ch_a, dat_a, {16'(100 + k), 104'(k)}); end
      @(negedge clk);
    end
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL bp_drained: got %b want 1", empty_a); end
  endtask

  task automatic test_drop();
    logic [119:0] exp;
    logic [1:0]   ech;
    int           j;
    do_reset();
    vld = 4'b1001;
    for (int k = 0; k < 20; k++) begin
      set_ch(0, 128'(32'h100 + k), 16'(16'h0A00 + k));
      set_ch(3, 128'(32'h300 + k), 16'(16'h0D00 + k));
      @(negedge clk);
    end
    vld = '0;
    checks++; if (drop_b !== 32'd8) begin errors++; $display("FAIL drop_cnt8: got %0d want 8", drop_b); end
    checks++; if (drop_a !== 32'd0) begin errors++; $display("FAIL bp_no_drop: got %0d want 0", drop_a); end
    checks++; if (nf_b !== 4'b1001) begin errors++; $display("FAIL drop_nf: got %b want 1001", nf_b); end
    checks++; if (rdy_a !== 4'b0110) begin errors++; $display("FAIL bp_rdy2: got %b want 0110", rdy_a); end
    rd_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      j   = k / 2;
      ech = (k % 2 == 1) ? 2'd3 : 2'd0;
      exp = (k % 2 == 1) ? {16'(16'h0D00 + j), 104'(32'h300 + j)} : {16'(16'h0A00 + j), 104'(32'h100 + j)};
      checks++; if (ch_b !== ech || dat_b !== exp) begin errors++; $display("FAIL drop_drain%0d: got ch %0d %h want ch %0d %h", k, ch_b, dat_b, ech, exp); end
      checks++; if (ch_a !== ech || dat_a !== exp) begin errors++; $display("FAIL bp_drain2_%0d: got ch %0d %h want ch %0d %h", k, ch_a, dat_a, ech, exp); end
      @(negedge clk);
    end
    rd_en = 1'b0;
    checks++; if (empty_b !== 1'b1 || empty_a !== 1'b1) begin errors++; $display("FAIL drop_drained: got %b%b want 11", empty_a, empty_b); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      vld = 4'b0001;
      for (int k = 0; k < 16; k++) begin
        set_ch(0, 128'(r * 16 + k), 16'(r));
        @(negedge clk);
      end
      vld = '0;
      rd_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
        checks++; if (dat_a !== {16'(r), 104'(r * 16 + k)}) begin errors++; $display("FAIL wrap_r%0d_%0d: got %h want %h", r, k, dat_a, {16'(r), 104'(r * 16 + k)}); end
        @(negedge clk);
      end
      rd_en = 1'b0;
      checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL wrap_empty%0d: got %b want 1", r, empty_a); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_ch(0, 128'h0, 16'h7);
    vld = 4'b0001;
    @(negedge clk);
    rd_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (dat_a !== {16'h7, 104'(k - 1)}) begin errors++; $display("FAIL b2b_%0d: got %h want %h", k, dat_a, {16'h7, 104'(k - 1)}); end
      set_ch(0, 128'(k), 16'h7);
      @(negedge clk);
    end
    vld = '0;
    checks++; if (dat_a !== {16'h7, 104'd6} || empty_a !== 1'b0) begin errors++; $display("FAIL b2b_last: got %h empty %b want %h empty 0", dat_a, empty_a, {16'h7, 104'd6}); end
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      set_ch(1, 128'(k), 16'h1);
      set_ch(2, 128'(k), 16'h2);
      vld = (k < 5) ? 4'b0110 : 4'b0010;
      @(negedge clk);
    end
    vld = '0;
    checks++; if (drop_b !== 32'd1 || empty_a !== 1'b0) begin errors++; $display("FAIL pre_reset: got drop %0d empty %b want drop 1 empty 0", drop_b, empty_a); end
    reset = 1'b1;
    #1;
    checks++; if (empty_a !== 1'b1 || empty_b !== 1'b1) begin errors++; $display("FAIL async_empty: got %b%b want 11", empty_a, empty_b); end
    checks++; if (drop_b !== 32'd0) begin errors++; $display("FAIL async_drop: got %0d want 0", drop_b); end
    checks++; if (nf_a !== 4'h0 || ch_a !== 2'd0) begin errors++; $display("FAIL async_nf_ch: got nf %h ch %0d want 0 0", nf_a, ch_a); end
    @(negedge clk);
    reset = 1'b0;
    set_ch(2, 128'h77, 16'h2);
    vld = 4'b0100;
    @(negedge clk);
    vld = '0;
    checks++; if (ch_a !== 2'd2 || dat_a !== {16'h2, 104'h77}) begin errors++; $display("FAIL post_reset: got ch %0d %h want ch 2 %h", ch_a, dat_a, {16'h2, 104'h77}); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b want 1", empty_a); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
